// File: rtl/wave_grid_solver.sv
// 2-D damped wave-equation grid: every node advances one time step per clock while running,
// with a clamped (zero) border, a host write port for initial displacements and a probe stream.
module wave_grid_solver #(
  parameter int GRID_ROWS  = 8,
  parameter int GRID_COLS  = 8,
  parameter int DATA_W     = 18,
  parameter int DAMP_SHIFT = 9,
  parameter int STEP_W     = 16,
  localparam int NODES  = GRID_ROWS * GRID_COLS,
  localparam int ADDR_W = $clog2(NODES),
  localparam int ROW_W  = $clog2(GRID_ROWS),
  localparam int COL_W  = $clog2(GRID_COLS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     halt_i,
  input  logic                     init_we_i,
  input  logic [ADDR_W-1:0]        init_addr_i,
  input  logic [DATA_W-1:0]        init_data_i,
  input  logic signed [DATA_W-1:0] rho_i,
  input  logic [STEP_W-1:0]        num_steps_i,
  input  logic [ROW_W-1:0]         probe_row_i,
  input  logic [COL_W-1:0]         probe_col_i,
  output logic [DATA_W-1:0]        sample_out_o,
  output logic                     sample_valid_o,
  output logic [STEP_W-1:0]        step_count_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int SUM_W = DATA_W + 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(GRID_ROWS - 1);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(GRID_COLS - 1);
  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] u_q    [NODES];
  logic signed [DATA_W-1:0] prev_q [NODES];
  logic signed [DATA_W-1:0] u_d    [NODES];
  logic [STEP_W-1:0]        step_cnt_q;
  logic [STEP_W-1:0]        nsteps_q;
  logic [ROW_W-1:0]         prow_q;
  logic [COL_W-1:0]         pcol_q;
  logic [DATA_W-1:0]        sample_q;
  logic                     valid_q;
  logic                     done_q;

  logic                     start_w;
  logic                     step_w;
  logic                     wr_w;
  logic                     last_step_w;
  logic [ROW_W-1:0]         prow_c;
  logic [COL_W-1:0]         pcol_c;
  logic [ADDR_W-1:0]        probe_idx_w;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(SUM_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // A start in the same cycle as a write takes priority and drops the write.
  assign start_w     = (state_q == ST_IDLE) && start_i;
  assign wr_w        = (state_q == ST_IDLE) && init_we_i && !start_i;
  assign step_w      = (state_q == ST_RUN) && !halt_i;
  assign last_step_w = (step_cnt_q + STEP_W'(1)) == nsteps_q;

  assign prow_c      = (probe_row_i > ROW_MAX) ? ROW_MAX : probe_row_i;
  assign pcol_c      = (probe_col_i > COL_MAX) ? COL_MAX : probe_col_i;
  assign probe_idx_w = ADDR_W'(prow_q) * ADDR_W'(GRID_COLS) + ADDR_W'(pcol_q);

  generate
    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
      localparam int R = gi / GRID_COLS;
      localparam int C = gi % GRID_COLS;

      logic signed [SUM_W-1:0]        n_up, n_dn, n_lf, n_rt;
      logic signed [SUM_W-1:0]        cur, prv, lap, diff, term, sum;
      logic signed [DATA_W+SUM_W-1:0] prod;
      logic [SUM_W-DATA_W:0]          top;
      logic                           ovf;

      // Off-grid neighbours are the clamped border and read as zero.
      if (R > 0) begin : g_up
        assign n_up = sext(u_q[gi-GRID_COLS]);
      end else begin : g_up_edge
        assign n_up = '0;
      end
      if (R < GRID_ROWS - 1) begin : g_dn
        assign n_dn = sext(u_q[gi+GRID_COLS]);
      end else begin : g_dn_edge
        assign n_dn = '0;
      end
      if (C > 0) begin : g_lf
        assign n_lf = sext(u_q[gi-1]);
      end else begin : g_lf_edge
        assign n_lf = '0;
      end
      if (C < GRID_COLS - 1) begin : g_rt
        assign n_rt = sext(u_q[gi+1]);
      end else begin : g_rt_edge
        assign n_rt = '0;
      end

      assign cur  = sext(u_q[gi]);
      assign prv  = sext(prev_q[gi]);
      assign lap  = n_up + n_dn + n_lf + n_rt - (cur <<< 2);
      assign prod = rho_i * lap;
      assign term = SUM_W'(prod >>> (DATA_W - 1));
      assign diff = cur - prv;
      assign sum  = term + (cur <<< 1) - prv - (diff >>> DAMP_SHIFT);

      // Overflow when the bits above the result's sign bit disagree with it.
      assign top    = sum[SUM_W-1:DATA_W-1];
      assign ovf    = (|top) && !(&top);
      assign u_d[gi] = !ovf ? sum[DATA_W-1:0] : (sum[SUM_W-1] ? NEG_MIN : POS_MAX);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = (num_steps_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (halt_i)           state_d = ST_IDLE;
        else if (last_step_w) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      nsteps_q   <= '0;
      prow_q     <= '0;
      pcol_q     <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NODES; i++) begin
        u_q[i]    <= '0;
        prev_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= step_w;
      done_q  <= (state_q == ST_DONE);
      if (start_w) begin
        step_cnt_q <= '0;
        nsteps_q   <= num_steps_i;
        prow_q     <= prow_c;
        pcol_q     <= pcol_c;
      end else if (step_w) begin
        step_cnt_q <= step_cnt_q + STEP_W'(1);
        sample_q   <= u_d[probe_idx_w];
      end
      // Starting copies u into u_prev so every run begins with zero velocity.
      for (int i = 0; i < NODES; i++) begin
        if (step_w) begin
          prev_q[i] <= u_q[i];
          u_q[i]    <= u_d[i];
        end else if (start_w) begin
          prev_q[i] <= u_q[i];
        end else if (wr_w && (init_addr_i == ADDR_W'(i))) begin
          u_q[i] <= init_data_i;
        end
      end
    end
  end

  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign step_count_o   = step_cnt_q;
  assign busy_o         = (state_q == ST_RUN);
  assign done_o         = done_q;

endmodule
